// File: rtl/prbs_test_sequencer.sv
// PRBS link-test run controller: reseed, lock search, fixed measurement window, error count, LED.
// Optional macro PRBS_SEQ_RESYNC_EN: 8 consecutive errored bits in RUN drop back to SYNC.
module prbs_test_sequencer #(
    parameter int LOCK_LEN     = 64,
    parameter int SYNC_TIMEOUT = 4096,
    parameter int RUN_LEN      = 1000000,
    parameter int BLINK_DIV    = 12500000,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             prbs_valid,
    input  logic             PRBS_error,
    output logic             seed_load,
    output logic             chk_en,
    output logic             blinker,
    output logic             led,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state,
    output logic             pass,
    output logic             sync_fail
`ifdef PRBS_SEQ_RESYNC_EN
    ,
    output logic [7:0]       resync_count
`endif
);

    localparam int LOCK_W  = $clog2(LOCK_LEN + 1);
    localparam int TMO_W   = $clog2(SYNC_TIMEOUT + 1);
    localparam int RUN_W   = $clog2(RUN_LEN + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t cur_state, next_state;

    logic [BLINK_W-1:0] blink_cnt;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [TMO_W-1:0]   timeout_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic [ERR_W-1:0]   err_next;

    logic good_bit, bad_bit;
    logic lock_hit, timeout_hit, run_hit;
    logic seed_load_d, chk_en_d, led_d;

    assign good_bit    = prbs_valid && !PRBS_error;
    assign bad_bit     = prbs_valid && PRBS_error;
    assign lock_hit    = good_bit && (lock_cnt == LOCK_W'(LOCK_LEN - 1));
    assign timeout_hit = prbs_valid && (timeout_cnt == TMO_W'(SYNC_TIMEOUT - 1));
    assign run_hit     = prbs_valid && (run_cnt == RUN_W'(RUN_LEN - 1));
    assign err_next    = (bad_bit && !(&err_count)) ? err_count + ERR_W'(1) : err_count;

`ifdef PRBS_SEQ_RESYNC_EN
    logic [2:0] burst_cnt;
    logic       resync_hit;
    assign resync_hit = bad_bit && (burst_cnt == 3'd7);
`endif

    assign state = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= IDLE;
            seed_load <= 1'b0;
            chk_en    <= 1'b0;
            led       <= 1'b0;
        end else begin
            cur_state <= next_state;
            seed_load <= seed_load_d;
            chk_en    <= chk_en_d;
            led       <= led_d;
        end
    end

    // stop beats lock/completion; lock beats timeout on the same bit
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE, DONE: begin
                if (start) next_state = SYNC;
            end
            SYNC: begin
                if (stop)             next_state = DONE;
                else if (lock_hit)    next_state = RUN;
                else if (timeout_hit) next_state = DONE;
            end
            RUN: begin
                if (stop)            next_state = DONE;
                else if (run_hit)    next_state = DONE;
`ifdef PRBS_SEQ_RESYNC_EN
                else if (resync_hit) next_state = SYNC;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        seed_load_d = (next_state == SYNC) && (cur_state != SYNC);
        chk_en_d    = (next_state == SYNC) || (next_state == RUN);
        led_d       = 1'b0;
        case (cur_state)
            IDLE:    led_d = 1'b0;
            SYNC:    led_d = blinker;
            RUN:     led_d = (err_count == '0) ? 1'b1 : blinker;
            DONE:    led_d = pass ? 1'b1 : blinker;
            default: led_d = 1'b0;
        endcase
    end

    // free-running blink prescaler, independent of the sequencer state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blinker   <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blinker   <= ~blinker;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt     <= '0;
            timeout_cnt  <= '0;
            run_cnt      <= '0;
            err_count    <= '0;
            pass         <= 1'b0;
            sync_fail    <= 1'b0;
`ifdef PRBS_SEQ_RESYNC_EN
            burst_cnt    <= '0;
            resync_count <= '0;
`endif
        end else begin
            case (cur_state)
                IDLE, DONE: begin
                    if (start) begin
                        lock_cnt     <= '0;
                        timeout_cnt  <= '0;
                        run_cnt      <= '0;
                        err_count    <= '0;
                        pass         <= 1'b0;
                        sync_fail    <= 1'b0;
`ifdef PRBS_SEQ_RESYNC_EN
                        burst_cnt    <= '0;
                        resync_count <= '0;
`endif
                    end
                end
                SYNC: begin
                    if (stop) begin
                        pass      <= 1'b0;
                        sync_fail <= 1'b0;
                    end else if (prbs_valid) begin
                        if (lock_hit) begin
                            lock_cnt    <= '0;
                            timeout_cnt <= '0;
`ifdef PRBS_SEQ_RESYNC_EN
                            burst_cnt   <= '0;
`endif
                        end else begin
                            lock_cnt    <= PRBS_error ? '0 : lock_cnt + LOCK_W'(1);
                            timeout_cnt <= timeout_cnt + TMO_W'(1);
                            if (timeout_hit) begin
                                sync_fail <= 1'b1;
                                pass      <= 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        pass      <= 1'b0;
                        sync_fail <= 1'b0;
                    end else if (prbs_valid) begin
                        run_cnt   <= run_cnt + RUN_W'(1);
                        err_count <= err_next;
                        if (run_hit) pass <= (err_next == '0);
`ifdef PRBS_SEQ_RESYNC_EN
                        if (!PRBS_error) begin
                            burst_cnt <= '0;
                        end else if (resync_hit && !run_hit) begin
                            burst_cnt   <= '0;
                            lock_cnt    <= '0;
                            timeout_cnt <= '0;
                            if (resync_count != 8'hFF) resync_count <= resync_count + 8'd1;
                        end else begin
                            burst_cnt <= burst_cnt + 3'd1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// Directed bench for prbs_test_sequencer with small parameters (LOCK 4, TIMEOUT 10, RUN 16, BLINK 3, ERR_W 2).
module tb_prbs_test_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       prbs_valid = 1'b0;
    logic       PRBS_error = 1'b0;
    logic       seed_load, chk_en, blinker, led, pass, sync_fail;
    logic [1:0] err_count;
    logic [1:0] state;
`ifdef PRBS_SEQ_RESYNC_EN
    logic [7:0] resync_count;
`endif

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    prbs_test_sequencer #(
        .LOCK_LEN(4), .SYNC_TIMEOUT(10), .RUN_LEN(16), .BLINK_DIV(3), .ERR_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .prbs_valid(prbs_valid), .PRBS_error(PRBS_error),
        .seed_load(seed_load), .chk_en(chk_en), .blinker(blinker), .led(led),
        .err_count(err_count), .state(state), .pass(pass), .sync_fail(sync_fail)
`ifdef PRBS_SEQ_RESYNC_EN
        , .resync_count(resync_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // one clock cycle with the given inputs; outputs are sampled 1 time unit after the edge
    task automatic applyStimulus(input logic s, input logic p, input logic v, input logic e);
        start = s; stop = p; prbs_valid = v; PRBS_error = e;
        @(posedge clk);
        #1;
        cycles++;
        start = 1'b0; stop = 1'b0; prbs_valid = 1'b0; PRBS_error = 1'b0;
    endtask

    // blinker after edge c since reset release: toggles on edges 3, 6, 9, ...
    function automatic logic blinkExp(input int c);
        return ((c / 3) % 2) == 1;
    endfunction

    task automatic lockUp();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_seed", seed_load, 0);
        checkOutput("reset_chk_en", chk_en, 0);
        checkOutput("reset_blinker", blinker, 0);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_err", err_count, 0);
        checkOutput("reset_pass_fail", {pass, sync_fail}, 0);
        reset = 1'b1;
        cycles = 0;

        // clean run to completion
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_state_sync", state, 1);
        checkOutput("t1_seed_pulse", seed_load, 1);
        checkOutput("t1_chk_en", chk_en, 1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 1) checkOutput("t1_seed_one_cycle", seed_load, 0);
            if (i == 3) checkOutput("t1_still_sync", state, 1);
        end
        checkOutput("t1_state_run", state, 2);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 15) checkOutput("t1_run_bit15", state, 2);
        end
        checkOutput("t1_state_done", state, 3);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_err", err_count, 0);
        checkOutput("t1_chk_en_off", chk_en, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("t1_led", led, 1);
        checkOutput("t1_blinker", blinker, blinkExp(cycles));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_stop_ignored_done", state, 3);
        checkOutput("t1_pass_held", pass, 1);

        // errors on RUN bits 3 and 16
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_state_sync", state, 1);
        checkOutput("t2_seed_pulse", seed_load, 1);
        checkOutput("t2_pass_cleared", pass, 0);
        lockUp();
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i == 3 || i == 16));
            if (i == 15) begin
                checkOutput("t2_err_bit15", err_count, 1);
                checkOutput("t2_state_bit15", state, 2);
            end
        end
        checkOutput("t2_state_done", state, 3);
        checkOutput("t2_err", err_count, 2);
        checkOutput("t2_pass", pass, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("t2_led_blink", led, blinkExp(cycles - 1));
        end

        // sync timeout, errors on every third valid bit, with ignored non-valid cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_state_sync", state, 1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i % 3 == 0));
            if (i == 5) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (i == 9) checkOutput("t3_still_sync_bit9", state, 1);
        end
        checkOutput("t3_state_done", state, 3);
        checkOutput("t3_sync_fail", sync_fail, 1);
        checkOutput("t3_pass", pass, 0);
        checkOutput("t3_chk_en", chk_en, 0);

        // stop at RUN bit 5 with one error so far
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_sync_fail_cleared", sync_fail, 0);
        lockUp();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, (i == 2));
        checkOutput("t4_state_run", state, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_state_done", state, 3);
        checkOutput("t4_pass", pass, 0);
        checkOutput("t4_sync_fail", sync_fail, 0);
        checkOutput("t4_err_held", err_count, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_restart_state", state, 1);
        checkOutput("t4_restart_err", err_count, 0);
        checkOutput("t4_restart_seed", seed_load, 1);

        // lock counter reset by an error, then saturation of err_count at 3
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i == 3));
            if (i == 6) checkOutput("t5_lock_restarted", state, 1);
        end
        checkOutput("t5_state_run", state, 2);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i <= 6));
            if (i == 3) checkOutput("t5_err_at_3", err_count, 3);
            if (i == 6) checkOutput("t5_err_saturated", err_count, 3);
        end
        checkOutput("t5_state_done", state, 3);
        checkOutput("t5_err_final", err_count, 3);
        checkOutput("t5_pass", pass, 0);

        // asynchronous reset mid-RUN
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        lockUp();
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, (i == 2));
        checkOutput("t6_pre_err", err_count, 1);
        reset = 1'b0;
        #1;
        checkOutput("t6_async_state", state, 0);
        checkOutput("t6_async_chk_en", chk_en, 0);
        checkOutput("t6_async_err", err_count, 0);
        checkOutput("t6_async_led_blink", {led, blinker}, 0);
        checkOutput("t6_async_seed", seed_load, 0);
        #1;
        reset = 1'b1;
        cycles = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_idle_after_reset", state, 0);
        checkOutput("t6_blink_c1", blinker, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_blink_c2", blinker, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_blink_c3", blinker, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
